serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder with carry-in and a start/busy/done handshake.
- Instantiates the team's combinational full_adder cell (ports a, b, cin, sum, cout) as its single datapath element and processes one bit per clock, LSB first.
- A registered carry flip-flop links successive bits.
- Sits directly downstream of the full_adder cell: it consumes sum/cout each cycle and builds the multi-bit result.
- Used where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request: sample a, b, cin and begin an addition
- a      input   WIDTH  operand A, sampled only on an accepted start
- b      input   WIDTH  operand B, sampled only on an accepted start
- cin    input   1      carry-in, sampled only on an accepted start
- busy   output  1      high while an addition is in progress
- done   output  1      one-cycle pulse: sum/cout valid
- sum    output  WIDTH  result, held until the next accepted start
- cout   output  1      final carry-out, held with sum

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0, the following are all 0: state=IDLE, busy, done, sum, cout, internal shift registers, carry flop and bit counter.
- State machine: IDLE, RUN, DONE.
- IDLE, start=1 at a clock edge:
  - Load shift registers A<=a, B<=b, carry<=cin, counter<=0.
  - Go to RUN; busy=1 from the next cycle.
- RUN, each edge:
  - full_adder inputs are A[0], B[0], carry.
  - carry<=fa.cout.
  - The sum shift register shifts right, with fa.sum entering at bit WIDTH-1.
  - A and B shift right.
  - counter increments.
- RUN exit: on the edge where counter reaches WIDTH-1, the last bit is processed and the state goes to DONE.
  - sum holds the complete result; cout<=fa.cout.
  - busy<=0, done<=1.
- DONE: lasts exactly one cycle.
  - done falls to 0 at the next edge and the state returns to IDLE.
  - If start=1 in the DONE cycle, it is accepted exactly as in IDLE, giving back-to-back operation.
- Latency:
  - start sampled at edge E0; busy is high for cycles E0..E0+WIDTH-1.
  - done is high in the cycle after edge E0+WIDTH.
  - Throughput is one result per WIDTH+1 cycles.
- start during RUN: ignored; operands are not resampled.
- sum/cout stability:
  - During RUN, sum shows the partially shifted value and is not valid.
  - Consumers use sum/cout only when done=1, or any time afterwards until the next accepted start.
  - Once valid, sum/cout stay stable in IDLE.
- Width rules:
  - Result is the modulo-2^WIDTH sum, with the carry out of bit WIDTH-1 on cout.
  - Counter width is clog2(WIDTH).
- Reset mid-operation: the addition is aborted immediately, all outputs return to 0 and no done pulse is produced.
- start held high continuously: a new addition is accepted in every DONE cycle.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- With the macro defined:
  - Extra output port ovf (output, 1 bit), registered alongside cout.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, i.e. two's-complement signed overflow.
  - ovf resets to 0, updates only on the DONE transition, and is held with sum.
- Without the macro: the ovf port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Zero case: WIDTH=8, a=0x00, b=0x00, cin=0, start pulse at E0 -> busy high for 8 cycles; done=1 in the cycle after E0+8; sum=0x00, cout=0.
- Carry ripple: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1.
- Start ignored during RUN: start 0x12+0x34; re-pulse start with a=0xFF, b=0xFF at cycle 3 of RUN -> sum=0x46, cout=0, only one done pulse.
- Back-to-back: start held high, a=0x0F, b=0x01, then a=0x80, b=0x80 presented in the DONE cycle -> results 0x10/0 and then 0x00/1; done pulses 9 cycles apart.
- Reset mid-operation: assert rst_n=0 at RUN cycle 4 -> busy, done, sum, cout are 0 immediately (asynchronous). Release reset and run 0x03+0x04 -> sum=0x07.
- With SERIAL_ADDER_OVF_EN: 0x7F+0x01 -> sum=0x80, cout=0, ovf=1. 0xFF+0x01 -> sum=0x00, cout=1, ovf=0. Without the macro, the bench compiles with no ovf port.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder with carry-in and a start/busy/done
// handshake. One full_adder cell is shared over WIDTH clocks, LSB first, and a
// carry flop links successive bits.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_fa_sum;
  logic             w_fa_cout;

  // Single shared datapath element: operand LSBs plus the running carry.
  full_adder u_fa (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .sum  (w_fa_sum),
    .cout (w_fa_cout)
  );

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        // A start here is accepted exactly as in IDLE for back-to-back use.
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand/result shift registers, carry flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_sum   <= {w_fa_sum, r_sum[WIDTH-1:1]};
      r_carry <= w_fa_cout;
      r_cnt   <= r_cnt + CNT_W'(1);
    end else begin
      r_a     <= r_a;
      r_b     <= r_b;
      r_sum   <= r_sum;
      r_carry <= r_carry;
      r_cnt   <= r_cnt;
    end
  end

  // Registered handshake flags, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN);
      r_done <= (w_state_nxt == S_DONE);
    end
  end

  // Final carry-out captured on the last bit and held with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cout <= 1'b0;
    end else if (w_last) begin
      r_cout <= w_fa_cout;
    end else begin
      r_cout <= r_cout;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB (r_carry at the last step) XOR carry out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_carry ^ w_fa_cout;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): table-driven vectors through a
// scoreboard queue, plus hand-written sequences for ignored start, back-to-back
// operation and reset in the middle of an addition.

module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[11];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_done = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse pops one expected result and compares it.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      exp_t e;
      n_done++;
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sum", 64'(sum), 64'(e.s));
        chk("cout", 64'(cout), 64'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
        chk("ovf", 64'(ovf), 64'(e.o));
`endif
      end
    end
  end

  // One addition with a single-cycle start; checks latency, busy length and hold.
  task automatic run_one(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                         input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    int   lat;
    int   bcnt;
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    e.s = es; e.c = ec; e.o = eo;
    sb_q.push_back(e);
    @(negedge clk);  // first sample after accepting edge E0
    start = 1'b0;
    a = ~ia; b = ~ib;  // operands must not be resampled
    lat  = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 4 * W) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk("done_latency", 64'(lat), 64'(W));
    chk("busy_cycles", 64'(bcnt), 64'(W));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("sum_held", 64'(sum), 64'(es));
    chk("cout_held", 64'(cout), 64'(ec));
  endtask

  initial begin
    int           d0;
    int           gap;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   full;
    logic         ro;

    vecs[0]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4]  = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
    vecs[5]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6]  = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0};
    vecs[8]  = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[9]  = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0};
    vecs[10] = '{8'h80, 8'hFF, 1'b1, 8'h80, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      run_one(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].c, vecs[i].o);
    end

    // Random vectors against an arithmetic model
    for (int i = 0; i < 6; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      ro = (ra[W-1] == rb[W-1]) && (full[W-1] != ra[W-1]);
      run_one(ra, rb, rc, full[W-1:0], full[W], ro);
    end

    // Start during RUN is ignored
    d0 = n_done;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    sb_q.push_back('{8'h46, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3 * W) @(negedge clk);
    chk("ignored_start_one_done", 64'(n_done - d0), 64'd1);

    // Back-to-back with start held high
    @(negedge clk);
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    sb_q.push_back('{8'h10, 1'b0, 1'b0});
    gap = 0;
    @(negedge clk);
    while (done !== 1'b1 && gap < 4 * W) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_first_done", 64'(done), 64'd1);
    a = 8'h80; b = 8'h80;
    sb_q.push_back('{8'h00, 1'b1, 1'b1});
    gap = 0;
    @(negedge clk);
    gap++;
    while (done !== 1'b1 && gap < 4 * W) begin
      @(negedge clk);
      gap++;
    end
    start = 1'b0;
    chk("b2b_done_gap", 64'(gap), 64'(W + 1));
    repeat (2 * W) @(negedge clk);
    chk("b2b_no_extra", 64'(sb_q.size()), 64'd0);

    // Reset in the middle of an addition
    d0 = n_done;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_cout", 64'(cout), 64'd0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("midrst_ovf", 64'(ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * W) @(negedge clk);
    chk("midrst_no_done", 64'(n_done - d0), 64'd0);
    run_one(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0);

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
